// File: rtl/voice_allocator_pkg.sv
// Shared definitions for the polyphony voice allocator.
// Contents: note/velocity widths, event type codes and the allocator FSM
// state type. No ports.
package synth_pkg;

   localparam int NOTE_W = 7;
   localparam int VEL_W  = 7;

   localparam logic [1:0] EV_NOTE_OFF = 2'd0;
   localparam logic [1:0] EV_NOTE_ON  = 2'd1;
   localparam logic [1:0] EV_ALL_OFF  = 2'd2;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      COMMIT
   } state_t;

endpackage

// File: rtl/voice_allocator_if.sv
// Event handshake and per-voice output bundle for voice_allocator.
// Ports (as interface members):
//   inEventValid/inEventType/inNote/inVelocity : event from the MIDI parser
//   outReady                                    : allocator idle, event accepted
//   outVoiceGate/Note/Velocity                  : per-slot voice state (packed)
//   outVoiceStart/outVoiceRelease/outSteal      : one-cycle strobes
// master = event source / voice consumer side, slave = allocator side.
interface voice_allocator_if #(
   parameter int NUM_VOICES = 4
);
   import synth_pkg::*;

   logic                         inEventValid;
   logic [1:0]                   inEventType;
   logic [NOTE_W-1:0]            inNote;
   logic [VEL_W-1:0]             inVelocity;
   logic                         outReady;
   logic [NUM_VOICES-1:0]        outVoiceGate;
   logic [NOTE_W*NUM_VOICES-1:0] outVoiceNote;
   logic [VEL_W*NUM_VOICES-1:0]  outVoiceVelocity;
   logic [NUM_VOICES-1:0]        outVoiceStart;
   logic [NUM_VOICES-1:0]        outVoiceRelease;
   logic                         outSteal;

   modport master (
      output inEventValid, inEventType, inNote, inVelocity,
      input  outReady, outVoiceGate, outVoiceNote, outVoiceVelocity,
             outVoiceStart, outVoiceRelease, outSteal
   );

   modport slave (
      input  inEventValid, inEventType, inNote, inVelocity,
      output outReady, outVoiceGate, outVoiceNote, outVoiceVelocity,
             outVoiceStart, outVoiceRelease, outSteal
   );

endinterface

// File: rtl/voice_allocator_voice_slot.sv
// One voice slot: holds gate, note, velocity and saturating age, and emits
// registered start/release strobes.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   alloc             : take a new note (gate=1, note/vel loaded, age=0)
//   retrig            : same note struck again (vel loaded, age=0)
//   rel               : release the held note (note/vel kept for the tail)
//   age_inc           : another slot took a note-on; age one step older
//   new_note, new_vel : note/velocity loaded on alloc/retrig
//   gate, note, vel, age : registered slot state
//   start, rel_strobe : one-cycle strobes following alloc/retrig and rel
module voice_slot
   import synth_pkg::*;
#(
   parameter int AGE_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alloc,
   input  logic              retrig,
   input  logic              rel,
   input  logic              age_inc,
   input  logic [NOTE_W-1:0] new_note,
   input  logic [VEL_W-1:0]  new_vel,
   output logic              gate,
   output logic [NOTE_W-1:0] note,
   output logic [VEL_W-1:0]  vel,
   output logic [AGE_W-1:0]  age,
   output logic              start,
   output logic              rel_strobe
);

   always_ff @(posedge clk) begin
      if (rst) begin
         gate       <= 1'b0;
         note       <= '0;
         vel        <= '0;
         age        <= '0;
         start      <= 1'b0;
         rel_strobe <= 1'b0;
      end else begin
         start      <= alloc | retrig;
         rel_strobe <= rel;
         if (alloc) begin
            gate <= 1'b1;
            note <= new_note;
            vel  <= new_vel;
            age  <= '0;
         end else if (retrig) begin
            vel <= new_vel;
            age <= '0;
         end else begin
            if (rel) gate <= 1'b0;
            if (age_inc && age != '1) age <= age + 1'b1;
         end
      end
   end

endmodule

// File: rtl/voice_allocator.sv
// Polyphony scheduler: accepts note-on/note-off/all-notes-off events and
// assigns them to voice slots (same-note retrigger, else lowest free slot,
// else steal the oldest gated slot).
// Ports:
//   inCLK_50MHZ : system clock
//   inRESET     : synchronous active-high reset
//   bus         : voice_allocator_if slave (event handshake + voice outputs)
// Each accepted event scans one slot per cycle, then commits in one cycle.
module voice_allocator
   import synth_pkg::*;
#(
   parameter int NUM_VOICES = 4,
   parameter int AGE_W      = 4
) (
   input  logic             inCLK_50MHZ,
   input  logic             inRESET,
   voice_allocator_if.slave bus
);

   localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

   state_t            state, state_nxt;
   logic [1:0]        ev_type;
   logic [NOTE_W-1:0] ev_note;
   logic [VEL_W-1:0]  ev_vel;
   logic [IDX_W-1:0]  idx;

   logic              match_found, free_found, old_found;
   logic [IDX_W-1:0]  match_idx, free_idx, old_idx;
   logic [AGE_W-1:0]  old_age;

   logic              ready, steal_nxt, steal_q;

   logic [NUM_VOICES-1:0] gate_q, start_q, rel_q;
   logic [NUM_VOICES-1:0] alloc, retrig, rel, age_inc;
   logic [NOTE_W-1:0]     note_q [NUM_VOICES];
   logic [VEL_W-1:0]      vel_q  [NUM_VOICES];
   logic [AGE_W-1:0]      age_q  [NUM_VOICES];

   for (genvar i = 0; i < NUM_VOICES; i++) begin : g_slot
      voice_slot #(.AGE_W(AGE_W)) u_slot (
         .clk        (inCLK_50MHZ),
         .rst        (inRESET),
         .alloc      (alloc[i]),
         .retrig     (retrig[i]),
         .rel        (rel[i]),
         .age_inc    (age_inc[i]),
         .new_note   (ev_note),
         .new_vel    (ev_vel),
         .gate       (gate_q[i]),
         .note       (note_q[i]),
         .vel        (vel_q[i]),
         .age        (age_q[i]),
         .start      (start_q[i]),
         .rel_strobe (rel_q[i])
      );
      assign bus.outVoiceNote[i*NOTE_W +: NOTE_W]    = note_q[i];
      assign bus.outVoiceVelocity[i*VEL_W +: VEL_W]  = vel_q[i];
   end

   assign bus.outReady        = ready;
   assign bus.outVoiceGate    = gate_q;
   assign bus.outVoiceStart   = start_q;
   assign bus.outVoiceRelease = rel_q;
   assign bus.outSteal        = steal_q;

   // State register plus event latch and scan results.
   always_ff @(posedge inCLK_50MHZ) begin
      if (inRESET) begin
         state       <= IDLE;
         ev_type     <= EV_NOTE_OFF;
         ev_note     <= '0;
         ev_vel      <= '0;
         idx         <= '0;
         match_found <= 1'b0;
         free_found  <= 1'b0;
         old_found   <= 1'b0;
         match_idx   <= '0;
         free_idx    <= '0;
         old_idx     <= '0;
         old_age     <= '0;
         steal_q     <= 1'b0;
      end else begin
         state   <= state_nxt;
         steal_q <= steal_nxt;
         case (state)
            IDLE: begin
               if (bus.inEventValid) begin
                  // A zero-velocity note-on is folded into note-off here so
                  // the commit decode only ever sees real note-ons.
                  ev_type     <= (bus.inEventType == EV_NOTE_ON && bus.inVelocity == '0)
                                 ? EV_NOTE_OFF : bus.inEventType;
                  ev_note     <= bus.inNote;
                  ev_vel      <= bus.inVelocity;
                  idx         <= '0;
                  match_found <= 1'b0;
                  free_found  <= 1'b0;
                  old_found   <= 1'b0;
                  match_idx   <= '0;
                  free_idx    <= '0;
                  old_idx     <= '0;
                  old_age     <= '0;
               end
            end
            SCAN: begin
               if (gate_q[idx] && note_q[idx] == ev_note && !match_found) begin
                  match_found <= 1'b1;
                  match_idx   <= idx;
               end
               if (!gate_q[idx] && !free_found) begin
                  free_found <= 1'b1;
                  free_idx   <= idx;
               end
               // Strictly greater: on equal ages the earlier (lower) slot stays.
               if (gate_q[idx] && (!old_found || age_q[idx] > old_age)) begin
                  old_found <= 1'b1;
                  old_idx   <= idx;
                  old_age   <= age_q[idx];
               end
               idx <= idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Next state, handshake and commit decode into per-slot controls.
   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      alloc     = '0;
      retrig    = '0;
      rel       = '0;
      age_inc   = '0;
      steal_nxt = 1'b0;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (bus.inEventValid) state_nxt = SCAN;
         end
         SCAN: begin
            if (idx == LAST_IDX) state_nxt = COMMIT;
         end
         COMMIT: begin
            state_nxt = IDLE;
            case (ev_type)
               EV_NOTE_ON: begin
                  if (match_found) begin
                     retrig[match_idx] = 1'b1;
                  end else if (free_found) begin
                     alloc[free_idx] = 1'b1;
                  end else begin
                     alloc[old_idx] = 1'b1;
                     steal_nxt      = 1'b1;
                  end
                  age_inc = gate_q & ~(alloc | retrig);
               end
               EV_NOTE_OFF: begin
                  if (match_found) rel[match_idx] = 1'b1;
               end
               EV_ALL_OFF: begin
                  rel = gate_q;
               end
               default: ;
            endcase
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator (NUM_VOICES=4, AGE_W=4): directed
// scenarios plus random events compared against an array-based slot model.
module tb_voice_allocator;

   localparam int NV      = 4;
   localparam int AW      = 4;
   localparam int AGE_MAX = (1 << AW) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   voice_allocator_if #(.NUM_VOICES(NV)) bus ();

   voice_allocator #(.NUM_VOICES(NV), .AGE_W(AW)) dut (
      .inCLK_50MHZ (clk),
      .inRESET     (rst),
      .bus         (bus)
   );

   int total = 0;
   int bad   = 0;

   int m_gate [NV];
   int m_note [NV];
   int m_vel  [NV];
   int m_age  [NV];
   int e_start, e_rel, e_steal;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < NV; i++) begin
         m_gate[i] = 0; m_note[i] = 0; m_vel[i] = 0; m_age[i] = 0;
      end
   endtask

   // Slot selection straight from the allocation rules.
   task automatic model_event(input int t, input int n, input int v);
      int s;
      s = -1;
      e_start = 0; e_rel = 0; e_steal = 0;
      if (t == 1 && v == 0) t = 0;
      if (t == 1) begin
         for (int i = 0; i < NV; i++) if (s < 0 && m_gate[i] != 0 && m_note[i] == n) s = i;
         if (s < 0) for (int i = 0; i < NV; i++) if (s < 0 && m_gate[i] == 0) s = i;
         if (s < 0) begin
            s = 0;
            for (int i = 1; i < NV; i++) if (m_age[i] > m_age[s]) s = i;
            e_steal = 1;
         end
         for (int i = 0; i < NV; i++)
            if (m_gate[i] != 0 && i != s && m_age[i] < AGE_MAX) m_age[i]++;
         m_gate[s] = 1; m_note[s] = n; m_vel[s] = v; m_age[s] = 0;
         e_start = 1 << s;
      end else if (t == 0) begin
         for (int i = 0; i < NV; i++) if (s < 0 && m_gate[i] != 0 && m_note[i] == n) s = i;
         if (s >= 0) begin
            m_gate[s] = 0;
            e_rel = 1 << s;
         end
      end else if (t == 2) begin
         for (int i = 0; i < NV; i++) if (m_gate[i] != 0) begin
            e_rel |= 1 << i;
            m_gate[i] = 0;
         end
      end
   endtask

   task automatic check_state(input string tag);
      logic [31:0] g, n, v;
      g = '0; n = '0; v = '0;
      for (int i = 0; i < NV; i++) begin
         g[i]         = (m_gate[i] != 0);
         n[i*7 +: 7]  = m_note[i][6:0];
         v[i*7 +: 7]  = m_vel[i][6:0];
      end
      check({tag, "_gate"}, 32'(bus.outVoiceGate), g);
      check({tag, "_note"}, 32'(bus.outVoiceNote), n);
      check({tag, "_vel"},  32'(bus.outVoiceVelocity), v);
   endtask

   task automatic check_strobes(input string tag, input int s, input int r, input int st);
      check({tag, "_start"}, 32'(bus.outVoiceStart), s);
      check({tag, "_release"}, 32'(bus.outVoiceRelease), r);
      check({tag, "_steal"}, 32'(bus.outSteal), st);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      model_clear();
   endtask

   task automatic send(input int t, input int n, input int v);
      int cnt;
      cnt = 0;
      @(negedge clk);
      while (!bus.outReady && cnt < 20) begin cnt++; @(negedge clk); end
      if (!bus.outReady) begin
         check("ready_timeout", 32'(bus.outReady), 1);
         return;
      end
      bus.inEventValid = 1'b1;
      bus.inEventType  = t[1:0];
      bus.inNote       = n[6:0];
      bus.inVelocity   = v[6:0];
      @(negedge clk);
      bus.inEventValid = 1'b0;
      cnt = 0;
      while (!bus.outReady && cnt < 20) begin cnt++; @(negedge clk); end
      check("busy_cycles", cnt, NV + 1);
      model_event(t, n, v);
      check_strobes("commit", e_start, e_rel, e_steal);
      check_state("commit");
      @(negedge clk);
      check_strobes("after", 0, 0, 0);
   endtask

   initial begin
      int r, n, v;
      bus.inEventValid = 1'b0;
      bus.inEventType  = '0;
      bus.inNote       = '0;
      bus.inVelocity   = '0;

      do_reset();
      check("rst_ready", 32'(bus.outReady), 1);
      check_state("rst");
      check_strobes("rst", 0, 0, 0);

      // single note-on
      send(1, 60, 100);
      check("t1_slot0_note", 32'(bus.outVoiceNote[6:0]), 60);

      // fill then steal oldest
      do_reset();
      send(1, 60, 100); send(1, 62, 100); send(1, 64, 100); send(1, 67, 100);
      send(1, 72, 90);
      check("steal_slot0_note", 32'(bus.outVoiceNote[6:0]), 72);

      // retrigger
      do_reset();
      send(1, 60, 100); send(1, 60, 40);
      check("retrig_vel", 32'(bus.outVoiceVelocity[6:0]), 40);

      // release then lowest-free reuse
      do_reset();
      send(1, 60, 100); send(1, 62, 100); send(0, 60, 0); send(1, 65, 77);
      check("reuse_slot1_note", 32'(bus.outVoiceNote[13:7]), 62);

      // velocity-0 note-on releases; unmatched note-off is inert
      do_reset();
      send(1, 60, 100); send(1, 60, 0); send(1, 60, 100); send(0, 99, 5);

      // reserved type is inert
      send(3, 60, 20);

      // age saturation: slot1 truly older than slot0, but both saturate -> slot0 stolen
      do_reset();
      send(1, 60, 10); send(1, 62, 10); send(1, 64, 10); send(1, 67, 10);
      send(0, 60, 0); send(1, 70, 10);
      for (int k = 0; k < 20; k++) send(1, 67, 10 + k);
      send(1, 75, 50);
      check("sat_steal_note", 32'(bus.outVoiceNote[6:0]), 75);

      // all-notes-off, then reset during scan
      do_reset();
      send(1, 60, 100); send(1, 62, 100); send(1, 64, 100);
      send(2, 0, 0);
      @(negedge clk);
      bus.inEventValid = 1'b1;
      bus.inEventType  = 2'd1;
      bus.inNote       = 7'd50;
      bus.inVelocity   = 7'd100;
      @(negedge clk);
      bus.inEventValid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_clear();
      check_state("midrst");
      check("midrst_ready", 32'(bus.outReady), 1);
      for (int k = 0; k < 6; k++) begin
         check("midrst_quiet_start", 32'(bus.outVoiceStart), 0);
         @(negedge clk);
      end

      // random traffic
      do_reset();
      for (int k = 0; k < 80; k++) begin
         r = $urandom_range(0, 11);
         n = 60 + $urandom_range(0, 7);
         v = $urandom_range(1, 127);
         if (r <= 6)       send(1, n, v);
         else if (r <= 9)  send(0, n, v);
         else if (r == 10) send(1, n, 0);
         else if ($urandom_range(0, 3) == 0) send(2, n, v);
         else              send(3, n, v);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Polyphony scheduler between MIDIParse and the per-voice SampleGenerator/EnvelopeFollower instances.
- Accepts note-on, note-off and all-notes-off events over a valid/ready handshake.
- Assigns each event to one of NUM_VOICES voice slots: same-note retrigger first, then the lowest free slot, then steals the oldest slot.
- Drives per-voice note, velocity and gate plus one-cycle start/release strobes.

Parameters:
- NUM_VOICES, 4, number of voice slots (2..16).
- AGE_W, 4, width of the per-voice saturating age counter.

Ports:
- inCLK_50MHZ  input  1  system clock.
- inRESET  input  1  synchronous active-high reset.
- inEventValid  input  1  event present.
- inEventType  input  2  0=note-off, 1=note-on, 2=all-notes-off, 3=reserved.
- inNote  input  7  MIDI note number.
- inVelocity  input  7  MIDI velocity.
- outReady  output  1  allocator idle; event accepted on an edge where inEventValid && outReady.
- outVoiceGate  output  NUM_VOICES  slot active (note held).
- outVoiceNote  output  7*NUM_VOICES  packed note per slot; slot i at [7i+6:7i].
- outVoiceVelocity  output  7*NUM_VOICES  packed velocity per slot.
- outVoiceStart  output  NUM_VOICES  one-cycle strobe: slot (re)triggered.
- outVoiceRelease  output  NUM_VOICES  one-cycle strobe: slot released.
- outSteal  output  1  one-cycle strobe: an active slot was stolen.

Behaviour:
- Single clock domain. Reset is synchronous and active-high; the clock and reset ports are inCLK_50MHZ and inRESET.
- Reset values:
  - all gates, notes, velocities, ages, strobes and outSteal = 0;
  - state IDLE;
  - outReady = 1 in the cycle after reset deasserts.
- Reset mid-operation: the in-flight event is discarded and no strobes are issued.
- FSM states IDLE, SCAN, COMMIT.
  - IDLE: outReady=1. On accept, latch type/note/velocity, clear scan results, go to SCAN with idx=0.
  - SCAN: one slot per cycle, idx 0..NUM_VOICES-1, outReady=0.
    - Records the first slot with gate=1 and note==latched note (match).
    - Records the first slot with gate=0 (free).
    - Records the gated slot with the largest age (oldest); on ties the lower index wins because the comparison is strictly greater.
    - After idx=NUM_VOICES-1, go to COMMIT.
  - COMMIT: apply the action below, assert strobes for exactly this one cycle, then return to IDLE.
- Latency: accepted at edge E0; voice regs and strobes update at edge E(NUM_VOICES+1). outReady is low for NUM_VOICES+1 cycles, giving a throughput of one event per NUM_VOICES+2 cycles.
- Note-on with velocity 0 is treated as note-off.
- Note-on, in priority order:
  - match exists: retrigger that slot; velocity updated, age=0, Start strobe.
  - else free slot exists: allocate it; gate=1, note and velocity set, age=0, Start strobe.
  - else steal the oldest slot; note and velocity overwritten, age=0, Start and outSteal strobes. Release is not strobed for a stolen slot.
- Age update on every note-on commit: each other gated slot's age increments, saturating at 2^AGE_W-1.
- Note-off:
  - match exists: gate=0, Release strobe; note and velocity are held so the envelope tail can use them.
  - no match: no effect and no strobe.
- All-notes-off: every gated slot goes to gate=0 with its Release strobe, in the same COMMIT cycle.
- Reserved type: accepted, takes the full scan latency, has no effect.
- Invariant: no two gated slots ever hold the same note.
- inEventValid held high while outReady=0 is simply not accepted; no queueing. The upstream block must hold the event.
- Ages of ungated slots are don't-care but are reset to 0 on allocation.

Decomposition:
- Package synth_pkg:
  - NOTE_W=7, VEL_W=7;
  - event type codes EV_NOTE_OFF, EV_NOTE_ON, EV_ALL_OFF;
  - the FSM state typedef.
- Sub-module voice_slot, one instance per slot:
  - holds gate, note, velocity and age;
  - inputs: alloc, retrig, release, age_inc;
  - outputs: registered state plus the start/release strobes.
- voice_allocator contains the FSM, the scan comparators and the strobe decode.

Test Plan (NUM_VOICES=4, AGE_W=4):
- Reset, then note-on 60/vel 100 -> after 5 cycles: slot0 gate=1, note=60, vel=100; outVoiceStart=0001 for 1 cycle; outReady was low for exactly 5 cycles.
- Note-on 60, 62, 64, 67, then 72 -> slots 0-3 filled in order; 72 steals slot0 (age 3, oldest); outSteal=1, Start=0001, slot0 note=72.
- Note-on 60 vel 100, then note-on 60 vel 40 -> slot0 retriggered with vel=40; slot1 stays ungated; Start=0001 twice.
- Note-on 60 and 62, note-off 60, note-on 65 -> Release=0001; 65 lands in slot0 (lowest free); slot1 still note 62.
- Note-on 60 with vel 0 and note-off 99 while 60 is active -> first releases slot0; second produces no strobes and no state change.
- Three notes active, all-notes-off -> Release=0111 in one cycle, all gates 0. Then inRESET pulsed mid-SCAN of a new note-on -> all outputs 0, no Start strobe.
